// File: rtl/gate_response_checker.sv
// gate_response_checker
// Self-checking monitor for a two-input NAND/NOR/XNOR gate stage. A run is
// started with `start`, accepts N_VECTORS samples (gaps allowed via
// `in_valid`), compares each sample against golden gate responses, counts
// and records mismatches, and compacts every sample into an 8-bit MISR.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          begin a run (honoured only in IDLE)
//   in_valid       a/b/c/d/e form a sample this cycle
//   a, b           gate-stage inputs
//   c, d, e        gate-stage outputs: NAND, NOR, XNOR
//   busy           high while a run is in progress
//   done           one-cycle pulse when a run completes
//   pass           last completed run had zero mismatches
//   err_count      saturating count of mismatching samples
//   first_err_idx  0-based index of the first mismatching sample
//   first_err_bits {c,d,e} mismatch mask of the first failing sample
//   signature      MISR value over all accepted samples
module gate_response_checker #(
    parameter int unsigned N_VECTORS = 10,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [2:0]       first_err_bits,
    output logic [7:0]       signature
);

    localparam int unsigned SMP_W    = $clog2(N_VECTORS + 1);
    localparam logic [7:0]  MISR_POLY = 8'h1D;
    localparam logic [7:0]  MISR_SEED = 8'hFF;
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic               busy_d, done_d, pass_d;
    logic [CNT_W-1:0]   err_count_d, first_err_idx_d;
    logic [2:0]         first_err_bits_d;
    logic [7:0]         signature_d;

    logic [2:0]         exp_bits_c;
    logic [2:0]         mask_c;
    logic               accept_c;
    logic               last_c;

    // Golden gate responses and per-sample mismatch mask.
    always_comb begin
        exp_bits_c = {~(a & b), ~(a | b), ~(a ^ b)};
        mask_c     = {c, d, e} ^ exp_bits_c;
        accept_c   = (state_q == RUN) && in_valid;
        last_c     = (smp_cnt_q == SMP_W'(N_VECTORS - 1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state_q;
        smp_cnt_d        = smp_cnt_q;
        busy_d           = 1'b0;
        done_d           = 1'b0;
        pass_d           = pass;
        err_count_d      = err_count;
        first_err_idx_d  = first_err_idx;
        first_err_bits_d = first_err_bits;
        signature_d      = signature;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = RUN;
                    busy_d           = 1'b1;
                    smp_cnt_d        = '0;
                    pass_d           = 1'b0;
                    err_count_d      = '0;
                    first_err_idx_d  = '0;
                    first_err_bits_d = '0;
                    signature_d      = MISR_SEED;
                end
            end

            RUN: begin
                busy_d = 1'b1;
                if (accept_c) begin
                    smp_cnt_d   = smp_cnt_q + SMP_W'(1);
                    signature_d = {signature[6:0], 1'b0}
                                ^ (signature[7] ? MISR_POLY : 8'h00)
                                ^ {3'b000, a, b, c, d, e};
                    if (mask_c != 3'b000) begin
                        // err_count never returns to zero within a run, so
                        // zero here marks the first failure even when saturated.
                        if (err_count == '0) begin
                            first_err_idx_d  = CNT_W'(smp_cnt_q);
                            first_err_bits_d = mask_c;
                        end
                        if (err_count != ERR_MAX) begin
                            err_count_d = err_count + CNT_W'(1);
                        end
                    end
                    if (last_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            smp_cnt_q      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_bits <= '0;
            signature      <= 8'h00;
        end else begin
            state_q        <= state_d;
            smp_cnt_q      <= smp_cnt_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_count_d;
            first_err_idx  <= first_err_idx_d;
            first_err_bits <= first_err_bits_d;
            signature      <= signature_d;
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed, table-driven bench for gate_response_checker. Three instances
// cover N_VECTORS=4, N_VECTORS=1 and a narrow CNT_W=2 saturation case.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, a, b, c, d, e;
    logic start4, start1, start6;

    logic       busy4, done4, pass4;
    logic [7:0] err4, idx4, sig4;
    logic [2:0] bits4;

    logic       busy1, done1, pass1;
    logic [7:0] err1, idx1, sig1;
    logic [2:0] bits1;

    logic       busy6, done6, pass6;
    logic [1:0] err6, idx6;
    logic [7:0] sig6;
    logic [2:0] bits6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gate_response_checker #(.N_VECTORS(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .first_err_idx(idx4), .first_err_bits(bits4), .signature(sig4)
    );

    gate_response_checker #(.N_VECTORS(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(idx1), .first_err_bits(bits1), .signature(sig1)
    );

    gate_response_checker #(.N_VECTORS(6), .CNT_W(2)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy6), .done(done6), .pass(pass6), .err_count(err6),
        .first_err_idx(idx6), .first_err_bits(bits6), .signature(sig6)
    );

    // One sample with the expected results visible after it is accepted.
    typedef struct packed {
        logic [4:0] smp;   // {a,b,c,d,e}
        logic [7:0] err;
        logic [7:0] idx;
        logic [2:0] bits;
    } vec_t;

    vec_t tbl [8];
    logic [4:0] good [4];

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [4:0] x);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {3'b000, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] x);
        in_valid = v;
        {a, b, c, d, e} = x;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sig_m;
    logic       vpat [7];
    int         gi;

    initial begin
        // Correct gate responses for ab = 00, 01, 10, 11.
        good[0] = 5'b00111;
        good[1] = 5'b01100;
        good[2] = 5'b10100;
        good[3] = 5'b11001;

        // Run 0: all correct.
        tbl[0] = '{smp: good[0], err: 8'd0, idx: 8'd0, bits: 3'b000};
        tbl[1] = '{smp: good[1], err: 8'd0, idx: 8'd0, bits: 3'b000};
        tbl[2] = '{smp: good[2], err: 8'd0, idx: 8'd0, bits: 3'b000};
        tbl[3] = '{smp: good[3], err: 8'd0, idx: 8'd0, bits: 3'b000};
        // Run 1: c inverted on sample 2 only.
        tbl[4] = '{smp: good[0],  err: 8'd0, idx: 8'd0, bits: 3'b000};
        tbl[5] = '{smp: good[1],  err: 8'd0, idx: 8'd0, bits: 3'b000};
        tbl[6] = '{smp: 5'b10000, err: 8'd1, idx: 8'd2, bits: 3'b100};
        tbl[7] = '{smp: good[3],  err: 8'd1, idx: 8'd2, bits: 3'b100};

        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        start4 = 1'b0; start1 = 1'b0; start6 = 1'b0;
        drive(1'b0, 5'b00000);
        tick; tick;

        // Reset state.
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst_pass", pass4, 1'b0);
        chk("rst_err", err4, 8'd0);
        chk("rst_idx", idx4, 8'd0);
        chk("rst_bits", bits4, 3'b000);
        chk("rst_sig", sig4, 8'h00);
        chk("rst_sig6", sig6, 8'h00);

        @(negedge clk);
        rst = 1'b0;

        // Two table-driven runs on the N_VECTORS=4 instance, back to back.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            start4 = 1'b1;
            drive(1'b1, good[3]);      // presented with start: must be ignored
            tick;
            chk("start_busy", busy4, 1'b1);
            chk("start_sig_seed", sig4, 8'hFF);
            chk("start_err_clr", err4, 8'd0);
            chk("start_pass_clr", pass4, 1'b0);
            sig_m = 8'hFF;
            for (int i = 0; i < 4; i++) begin
                vec_t v;
                v = tbl[r*4 + i];
                @(negedge clk);
                start4 = 1'b0;
                drive(1'b1, v.smp);
                tick;
                sig_m = misr(sig_m, v.smp);
                chk("run_err", err4, v.err);
                chk("run_idx", idx4, v.idx);
                chk("run_bits", bits4, v.bits);
                chk("run_sig", sig4, sig_m);
                chk("run_done", done4, i == 3);
                chk("run_busy", busy4, i != 3);
            end
            chk("run_pass", pass4, r == 0);
            // start during DONE is ignored; results hold into IDLE.
            @(negedge clk);
            start4 = 1'b1;
            drive(1'b1, 5'b00000);
            tick;
            chk("post_done_pulse", done4, 1'b0);
            chk("post_busy_ignored", busy4, 1'b0);
            chk("post_pass_hold", pass4, r == 0);
            chk("post_sig_hold", sig4, sig_m);
        end

        // in_valid gaps plus a mid-run start: only valid cycles advance.
        @(negedge clk);
        start4 = 1'b1;
        drive(1'b1, 5'b00000);
        tick;
        chk("gap_start_busy", busy4, 1'b1);
        sig_m = 8'hFF;
        gi = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start4 = (k == 2);
            if (vpat[k]) begin
                drive(1'b1, good[gi]);
                sig_m = misr(sig_m, good[gi]);
                gi++;
            end else begin
                drive(1'b0, 5'b00000);  // wrong response, must be ignored
            end
            tick;
            chk("gap_done", done4, k == 6);
            chk("gap_busy", busy4, k != 6);
        end
        chk("gap_err", err4, 8'd0);
        chk("gap_pass", pass4, 1'b1);
        chk("gap_sig", sig4, sig_m);
        @(negedge clk);
        start4 = 1'b0;
        drive(1'b0, 5'b00000);
        tick;

        // N_VECTORS=1: single sample, known signature.
        @(negedge clk);
        start1 = 1'b1;
        tick;
        @(negedge clk);
        start1 = 1'b0;
        drive(1'b1, 5'b00111);
        tick;
        chk("n1_sig", sig1, 8'hE4);
        chk("n1_pass", pass1, 1'b1);
        chk("n1_done", done1, 1'b1);
        chk("n1_err", err1, 8'd0);

        // CNT_W=2: every response fully inverted, count saturates at 3.
        @(negedge clk);
        drive(1'b0, 5'b00000);
        start6 = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            logic [4:0] s;
            s = good[i % 4];
            @(negedge clk);
            start6 = 1'b0;
            drive(1'b1, {s[4:3], ~s[2:0]});
            tick;
            chk("sat_err", err6, (i < 3) ? i + 1 : 3);
            chk("sat_done", done6, i == 5);
        end
        chk("sat_idx", idx6, 2'd0);
        chk("sat_bits", bits6, 3'b111);
        chk("sat_pass", pass6, 1'b0);

        // Reset after 2 of 4 samples (one failing), then rst+start together.
        @(negedge clk);
        drive(1'b0, 5'b00000);
        start4 = 1'b1;
        tick;
        @(negedge clk);
        start4 = 1'b0;
        drive(1'b1, good[0]);
        tick;
        @(negedge clk);
        drive(1'b1, 5'b01000);
        tick;
        chk("pre_rst_err", err4, 8'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, good[2]);
        tick;
        chk("mid_rst_busy", busy4, 1'b0);
        chk("mid_rst_done", done4, 1'b0);
        chk("mid_rst_pass", pass4, 1'b0);
        chk("mid_rst_err", err4, 8'd0);
        chk("mid_rst_idx", idx4, 8'd0);
        chk("mid_rst_bits", bits4, 3'b000);
        chk("mid_rst_sig", sig4, 8'h00);
        @(negedge clk);
        start4 = 1'b1;               // reset wins over start
        tick;
        chk("rst_start_busy", busy4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, good[k % 4]);
            tick;
            chk("no_done_after_rst", done4, 1'b0);
            chk("idle_after_rst", busy4, 1'b0);
        end

        // Clean run after reset.
        @(negedge clk);
        start4 = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            drive(1'b1, good[i]);
            tick;
        end
        chk("clean_done", done4, 1'b1);
        chk("clean_pass", pass4, 1'b1);
        chk("clean_err", err4, 8'd0);

        @(negedge clk);
        drive(1'b0, 5'b00000);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
